// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
// The Gray step table gives the forward successor of each {A,B} state.
package quad_pkg;

    typedef enum logic {
        INIT,
        TRACK
    } qd_state_t;

    localparam int FILT_W = 4;

    // Forward successor, indexed by the current {A,B}.
    // 00->01, 01->11, 11->10, 10->00.
    localparam logic [3:0][1:0] FWD_STEP = {2'b10, 2'b00, 2'b11, 2'b01};

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return FWD_STEP[ab];
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs and counter-side outputs of the quadrature decoder.
// The slave modport is the decoder side.
interface quad_decoder_if;

    logic       ENC_A;
    logic       ENC_B;
    logic       ENC_Z;
    logic       IDX_EN;
    logic       CLR;
    logic       UP;
    logic       DN;
    logic       LOAD;
    logic [7:0] LDATA;
    logic       ERR;
    logic [7:0] ERR_CNT;

    modport master (
        output ENC_A, ENC_B, ENC_Z, IDX_EN, CLR,
        input  UP, DN, LOAD, LDATA, ERR, ERR_CNT
    );

    modport slave (
        input  ENC_A, ENC_B, ENC_Z, IDX_EN, CLR,
        output UP, DN, LOAD, LDATA, ERR, ERR_CNT
    );

endinterface

// File: rtl/qd_filter.sv
// One-bit channel conditioner: a 2-flop synchronizer followed by a stability filter.
// The seed input forces the filtered value straight from the synchronizer.
module qd_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic seed,
    input  logic raw,
    output logic sync,
    output logic filt
);

    logic              s1;
    logic              s2;
    logic [FILT_W-1:0] run;

    assign sync = s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            run  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (seed) begin
                filt <= s2;
                run  <= '0;
            end else if (s2 == filt) begin
                run <= '0;
            end else if (run == FILT_W'(FILT_LEN - 1)) begin
                // This edge is the FILT_LEN-th consecutive disagreement.
                filt <= s2;
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: conditions A/B/Z, decodes Gray steps into UP/DN/ERR pulses,
// and issues LOAD requests from CLR or the index channel.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] IDX_VAL  = 8'h00
) (
    input  logic          CLK,
    input  logic          RES,
    quad_decoder_if.slave bus
);

    // Channel index 0 = A, 1 = B, 2 = Z.
    logic [2:0] raw;
    logic [2:0] sync;
    logic [2:0] filt;
    logic       seed;

    assign raw = {bus.ENC_Z, bus.ENC_B, bus.ENC_A};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_filt
            qd_filter #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk  (CLK),
                .rst  (RES),
                .seed (seed),
                .raw  (raw[i]),
                .sync (sync[i]),
                .filt (filt[i])
            );
        end
    endgenerate

    qd_state_t  state_q, state_d;
    logic [1:0] init_cnt_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= INIT;
            init_cnt_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT && init_cnt_q != 2'd2)
                init_cnt_q <= init_cnt_q + 2'd1;
        end
    end

    // Seeding waits until s2 carries a post-reset sample of the encoder.
    always_comb begin
        state_d = state_q;
        seed    = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q == 2'd2) begin
                    seed    = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK:   state_d = TRACK;
            default: state_d = INIT;
        endcase
    end

    logic [1:0] ab_q, ab_cur;
    logic       z_q, z_prev;
    logic       trk, moved;
    logic       step_up, step_dn, step_err, idx_evt;
    logic       up_q, dn_q, err_q, load_q;
    logic [7:0] ldata_q, err_cnt_q;

    assign trk      = (state_q == TRACK);
    assign moved    = trk && (ab_q != ab_cur);
    assign step_up  = moved && (fwd_next(ab_cur) == ab_q);
    assign step_dn  = moved && (fwd_next(ab_q) == ab_cur);
    assign step_err = moved && !step_up && !step_dn;
    assign idx_evt  = trk && z_q && !z_prev && bus.IDX_EN;

    always_ff @(posedge CLK) begin
        if (RES) begin
            ab_q      <= 2'b00;
            ab_cur    <= 2'b00;
            z_q       <= 1'b0;
            z_prev    <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
            ldata_q   <= 8'h00;
            err_cnt_q <= 8'h00;
        end else begin
            if (seed) begin
                ab_q   <= {sync[0], sync[1]};
                ab_cur <= {sync[0], sync[1]};
                z_q    <= sync[2];
                z_prev <= sync[2];
            end else begin
                ab_q   <= {filt[0], filt[1]};
                ab_cur <= ab_q;
                z_q    <= filt[2];
                z_prev <= z_q;
            end
            up_q   <= step_up;
            dn_q   <= step_dn;
            err_q  <= step_err;
            load_q <= bus.CLR | idx_evt;
            if (bus.CLR)
                ldata_q <= 8'h00;
            else if (idx_evt)
                ldata_q <= IDX_VAL;
            if (bus.CLR)
                err_cnt_q <= 8'h00;
            else if (step_err && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.UP      = up_q;
    assign bus.DN      = dn_q;
    assign bus.ERR     = err_q;
    assign bus.LOAD    = load_q;
    assign bus.LDATA   = ldata_q;
    assign bus.ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a random phase,
// every cycle compared against a sample-window reference model.
module tb_quad_decoder;

    localparam int         N    = 3;
    localparam logic [7:0] IDXV = 8'h40;
    localparam int         MAXC = 8192;

    logic CLK = 1'b0;
    logic RES = 1'b1;

    quad_decoder_if bus();

    quad_decoder #(.FILT_LEN(N), .IDX_VAL(IDXV)) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0;
    int n_up = 0, n_dn = 0, n_err = 0, n_load = 0;

    // Model: raw samples per edge, accepted values, and events due at later edges.
    logic       hist [3][MAXC];
    bit         s_up [MAXC+4];
    bit         s_dn [MAXC+4];
    bit         s_err[MAXC+4];
    bit         s_z  [MAXC+4];
    logic [2:0] m_filt = '0;
    bit         m_init = 1'b1;
    int         m_icnt = 0, m_bar = 0;
    logic       m_up = 0, m_dn = 0, m_err = 0, m_load = 0;
    logic [7:0] m_ldata = 8'h00, m_ecnt = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Quadrant position along the forward Gray cycle.
    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_edge();
        int         e;
        logic [2:0] raw, old;
        bit         idx, stable;
        int         d;
        e   = cyc;
        raw = {bus.ENC_Z, bus.ENC_B, bus.ENC_A};
        if (RES) begin
            for (int ch = 0; ch < 3; ch++) hist[ch][e] = 1'b0;
            m_filt = '0; m_init = 1'b1; m_icnt = 0;
            m_up = 0; m_dn = 0; m_err = 0; m_load = 0; m_ldata = 8'h00; m_ecnt = 8'h00;
            for (int k = 1; k <= 2; k++) begin
                s_up[e+k] = 0; s_dn[e+k] = 0; s_err[e+k] = 0; s_z[e+k] = 0;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++) hist[ch][e] = raw[ch];
            m_up   = s_up[e];
            m_dn   = s_dn[e];
            m_err  = s_err[e];
            idx    = s_z[e] && bus.IDX_EN;
            m_load = bus.CLR || idx;
            if (bus.CLR) m_ldata = 8'h00;
            else if (idx) m_ldata = IDXV;
            if (bus.CLR) m_ecnt = 8'h00;
            else if (m_err && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            if (m_init) begin
                if (m_icnt == 2) begin
                    for (int ch = 0; ch < 3; ch++) m_filt[ch] = hist[ch][e-2];
                    m_bar  = e - 1;
                    m_init = 1'b0;
                end else begin
                    m_icnt++;
                end
            end else begin
                old = m_filt;
                // Accept a channel once its last N usable samples all disagree with it.
                for (int ch = 0; ch < 3; ch++) begin
                    if (e - N - 1 >= m_bar) begin
                        stable = 1'b1;
                        for (int j = e - N - 1; j <= e - 2; j++)
                            if (hist[ch][j] == old[ch]) stable = 1'b0;
                        if (stable) m_filt[ch] = ~old[ch];
                    end
                end
                if (m_filt[1:0] != old[1:0]) begin
                    d = (gpos({m_filt[0], m_filt[1]}) - gpos({old[0], old[1]}) + 4) % 4;
                    case (d)
                        1:       s_up[e+2]  = 1'b1;
                        3:       s_dn[e+2]  = 1'b1;
                        default: s_err[e+2] = 1'b1;
                    endcase
                end
                if (m_filt[2] && !old[2]) s_z[e+2] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (cyc >= MAXC - 4) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 4);
            $fatal(1);
        end
        model_edge();
        cyc++;
        #1;
        chk("up",      bus.UP,      m_up);
        chk("dn",      bus.DN,      m_dn);
        chk("err",     bus.ERR,     m_err);
        chk("load",    bus.LOAD,    m_load);
        chk("ldata",   bus.LDATA,   m_ldata);
        chk("err_cnt", bus.ERR_CNT, m_ecnt);
        n_up   += int'(bus.UP);
        n_dn   += int'(bus.DN);
        n_err  += int'(bus.ERR);
        n_load += int'(bus.LOAD);
    endtask

    // Tick 1 is the first edge sampling the new value, so the pulse lands on tick N+4.
    task automatic hold(input logic [1:0] ab, input int n, output int up_at, output int dn_at);
        bus.ENC_A = ab[1];
        bus.ENC_B = ab[0];
        up_at = -1;
        dn_at = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.UP && up_at < 0) up_at = i;
            if (bus.DN && dn_at < 0) dn_at = i;
        end
    endtask

    initial begin
        int ua, da, b0, e0, l0;
        logic [1:0] fwd [4];
        logic [1:0] rev [4];
        int n;
        fwd = '{2'b01, 2'b11, 2'b10, 2'b00};
        rev = '{2'b10, 2'b11, 2'b01, 2'b00};
        bus.ENC_A = 0; bus.ENC_B = 0; bus.ENC_Z = 0; bus.IDX_EN = 0; bus.CLR = 0;
        RES = 1'b1;
        repeat (3) tick();
        chk("rst_ldata",  bus.LDATA, 8'h00);
        chk("rst_ecnt",   bus.ERR_CNT, 8'h00);
        chk("rst_pulses", {bus.UP, bus.DN, bus.LOAD, bus.ERR}, 4'b0000);
        RES = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 4; i++) begin
            hold(fwd[i], 10, ua, da);
            chk("fwd_up_lat", ua, N + 4);
            chk("fwd_no_dn",  da, -1);
        end
        for (int i = 0; i < 4; i++) begin
            hold(rev[i], 10, ua, da);
            chk("rev_dn_lat", da, N + 4);
            chk("rev_no_up",  ua, -1);
        end

        b0 = n_up + n_dn + n_err;
        bus.ENC_A = 1; tick(); tick();
        bus.ENC_A = 0; repeat (10) tick();
        chk("glitch_none", n_up + n_dn + n_err - b0, 0);
        hold(2'b01, 10, ua, da);
        chk("post_glitch_up", ua, N + 4);
        hold(2'b00, 10, ua, da);

        e0 = n_err; b0 = n_up + n_dn;
        hold(2'b11, 10, ua, da);
        chk("dbl_err",     n_err - e0, 1);
        chk("dbl_no_step", n_up + n_dn - b0, 0);
        chk("dbl_ecnt",    bus.ERR_CNT, 8'h01);
        hold(2'b10, 10, ua, da);
        chk("after_err_up", ua, N + 4);

        bus.IDX_EN = 1; l0 = n_load;
        bus.ENC_Z = 1;
        repeat (N + 3) tick();
        bus.CLR = 1; tick(); bus.CLR = 0;
        repeat (8) tick();
        chk("clr_idx_loads", n_load - l0, 1);
        chk("clr_idx_ldata", bus.LDATA, 8'h00);
        chk("clr_ecnt",      bus.ERR_CNT, 8'h00);
        bus.ENC_Z = 0; repeat (10) tick();
        l0 = n_load;
        bus.ENC_Z = 1; repeat (10) tick();
        chk("idx_loads", n_load - l0, 1);
        chk("idx_ldata", bus.LDATA, IDXV);
        bus.IDX_EN = 0;
        bus.ENC_Z = 0; repeat (10) tick();
        l0 = n_load;
        bus.ENC_Z = 1; repeat (10) tick();
        chk("idx_disabled", n_load - l0, 0);
        bus.ENC_Z = 0; repeat (10) tick();

        e0 = n_err;
        for (int i = 0; i < 260; i++) hold((i % 2 == 0) ? 2'b01 : 2'b10, 6, ua, da);
        repeat (4) tick();
        chk("sat_events", n_err - e0, 260);
        chk("sat_ecnt",   bus.ERR_CNT, 8'hFF);
        bus.CLR = 1; tick(); bus.CLR = 0;
        chk("clr_zero_ecnt", bus.ERR_CNT, 8'h00);

        bus.ENC_A = 1; bus.ENC_B = 1; RES = 1'b1;
        repeat (3) tick();
        RES = 1'b0;
        b0 = n_up + n_dn + n_err + n_load;
        repeat (20) tick();
        chk("init_no_pulse", n_up + n_dn + n_err + n_load - b0, 0);
        hold(2'b10, 10, ua, da);
        chk("init_seeded_up", ua, N + 4);

        b0 = n_up + n_dn + n_err;
        bus.ENC_A = 0; bus.ENC_B = 0;
        repeat (2) tick();
        RES = 1'b1; repeat (2) tick(); RES = 1'b0;
        repeat (20) tick();
        chk("rst_mid_no_pulse", n_up + n_dn + n_err - b0, 0);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 15);
            bus.ENC_A = 1'($urandom_range(0, 1));
            bus.ENC_B = 1'($urandom_range(0, 1));
            if (r == 0 || r == 5) bus.ENC_Z = ~bus.ENC_Z;
            if (r == 3) bus.IDX_EN = ~bus.IDX_EN;
            bus.CLR = (r == 1);
            RES     = (r == 2 && $urandom_range(0, 3) == 0);
            n = $urandom_range(1, 8);
            tick();
            bus.CLR = 0;
            RES     = 1'b0;
            repeat (n - 1) tick();
        end
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive stable cycles a synchronized input needs before it is accepted; legal range 1..15.
REQ-002 Parameter IDX_VAL, default 8'h00: value driven on LDATA when an index event loads the counter.
REQ-003 CLK  input  1  single clock; all logic is clocked on the rising edge.
REQ-004 RES  input  1  reset, synchronous and active-high.
REQ-005 ENC_A  input  1  raw encoder channel A, asynchronous.
REQ-006 ENC_B  input  1  raw encoder channel B, asynchronous.
REQ-007 ENC_Z  input  1  raw encoder index channel, asynchronous.
REQ-008 IDX_EN  input  1  enables index-driven loads; synchronous level.
REQ-009 CLR  input  1  synchronous request to load 8'h00.
REQ-010 UP  output  1  one-cycle count-up pulse toward the counter.
REQ-011 DN  output  1  one-cycle count-down pulse toward the counter.
REQ-012 LOAD  output  1  one-cycle load pulse toward the counter.
REQ-013 LDATA  output  8  load value, valid while LOAD=1.
REQ-014 ERR  output  1  one-cycle pulse on an illegal A/B transition.
REQ-015 ERR_CNT  output  8  saturating count of ERR pulses.

Function
REQ-016 Each of ENC_A/B/Z SHALL pass through a 2-flop synchronizer (s1, s2).
REQ-017 Each channel's filtered value SHALL update only after s2 differs from it for FILT_LEN consecutive edges; any return to equality SHALL clear the run counter.
REQ-018 The controller SHALL run an FSM with states INIT and TRACK.
REQ-019 INIT SHALL last 2 cycles after reset release; on exit, the filtered values SHALL be seeded directly from s2 with no UP, DN, ERR or LOAD pulse; the FSM then enters TRACK.
REQ-020 In TRACK, a filtered {A,B} step 00->01->11->10->00 SHALL produce UP=1 for exactly one cycle.
REQ-021 The reverse step sequence SHALL produce DN=1 for exactly one cycle.
REQ-022 A simultaneous change of both filtered bits SHALL produce ERR=1 for one cycle, no UP/DN, and the new value SHALL be adopted as the current state.
REQ-023 UP and DN SHALL never be 1 in the same cycle.
REQ-024 Latency: with FILT_LEN=N, a raw single-bit change stable from edge k SHALL produce the UP/DN pulse in the cycle following edge k+N+3.
REQ-025 A rising edge of filtered Z while IDX_EN=1 SHALL produce LOAD=1 for one cycle with LDATA=IDX_VAL.
REQ-026 CLR=1 SHALL produce LOAD=1 with LDATA=8'h00 in the following cycle; CLR has priority over an index event in the same cycle.
REQ-027 LOAD SHALL NOT suppress UP/DN; the downstream counter's LOAD-over-UP/DN priority applies.
REQ-028 ERR_CNT SHALL increment on each ERR pulse and hold at 8'hFF (no wrap); CLR SHALL zero it.
REQ-029 LDATA SHALL hold its last value while LOAD=0.

Reset
REQ-030 While RES=1: UP, DN, LOAD, ERR=0; LDATA=8'h00; ERR_CNT=8'h00; synchronizers, filters and run counters cleared; FSM=INIT.
REQ-031 RES asserted mid-transition SHALL discard the partial filter run; no pulse SHALL be emitted for it.

Structure
REQ-032 Package quad_pkg SHALL hold the FSM state enum (INIT, TRACK), the FILT_W=4 constant and the forward Gray step table.
REQ-033 Sub-module qd_filter (synchronizer plus stability filter, one bit) SHALL be instantiated three times (A, B, Z).

Verification
REQ-034 FILT_LEN=3, reset, then 4 forward steps 00->01->11->10->00, each held 10 cycles -> 4 UP pulses, each 6 cycles after its step, and DN=0 throughout.
REQ-035 Same sequence in reverse -> 4 DN pulses; then a 2-cycle glitch on A -> no pulse and filtered A unchanged.
REQ-036 Filtered state 00, then A and B raised in the same cycle -> ERR=1 for one cycle, no UP/DN, ERR_CNT=1; next step 11->10 -> UP.
REQ-037 IDX_VAL=8'h40, IDX_EN=1, Z rises together with CLR -> one LOAD pulse with LDATA=8'h00; Z rise alone -> LOAD with LDATA=8'h40; IDX_EN=0 -> no LOAD.
REQ-038 260 forced ERR events -> ERR_CNT holds 8'hFF; encoder resting at 11 through reset release -> no pulse out of INIT; RES mid-filter -> no pulse.
